// File: rtl/diff_freq_pkg.sv
// Shared constants for the dual-rate serial transmitter: FSM encoding, mode values, defaults.
package diff_freq_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_REPEAT  = 1'b1;

    localparam int   DEF_FAST_DIV   = 10;
    localparam int   DEF_SLOW_DIV   = 20;
    localparam logic DEF_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/bit_period_timer.sv
// Per-bit hold counter; o_period_end is combinational from the count, high on the last cycle of a bit.
// No backpressure: counts every cycle unless cleared.
module bit_period_timer
    import diff_freq_pkg::*;
#(
    parameter int FAST_DIV = DEF_FAST_DIV,
    parameter int SLOW_DIV = DEF_SLOW_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_sel_fast,
    output logic o_period_end
);

    localparam int MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
    localparam int CNT_W   = $clog2(MAX_DIV + 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_last;

    assign w_last       = i_sel_fast ? FAST_LAST : SLOW_LAST;
    assign o_period_end = (r_cnt == w_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || o_period_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/diff_freq_serial_tx.sv
// Latches pattern/freq/mode on start and shifts LSB-first, each bit held FAST_DIV or SLOW_DIV cycles.
// Output appears the cycle after start; no backpressure, i_stop aborts on the next edge.
module diff_freq_serial_tx
    import diff_freq_pkg::*;
#(
    parameter int   DATA_BIT   = 32,
    parameter int   FAST_DIV   = DEF_FAST_DIV,
    parameter int   SLOW_DIV   = DEF_SLOW_DIV,
    parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_BIT-1:0] i_output_pattern,
    input  logic [DATA_BIT-1:0] i_freq_pattern,
    input  logic                i_mode,
    input  logic                i_start,
    input  logic                i_stop,
    output logic                o_serial_out,
    output logic                o_busy,
    output logic                o_done_tick
);

    localparam int IDX_W = $clog2(DATA_BIT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BIT - 1);

    state_t              r_state;
    logic [DATA_BIT-1:0] r_pattern;
    logic [DATA_BIT-1:0] r_freq;
    logic                r_mode;
    logic [IDX_W-1:0]    r_bit_idx;
    logic                r_serial_out;
    logic                r_busy;
    logic                r_done_tick;

    logic             w_period_end;
    logic             w_clear;
    logic             w_last_bit;
    logic [IDX_W-1:0] w_next_idx;

    // Counter is held at zero while idle and restarted on any start or stop.
    assign w_clear    = (r_state == S_IDLE) || i_start || i_stop;
    assign w_last_bit = (r_bit_idx == LAST_IDX);
    assign w_next_idx = r_bit_idx + IDX_W'(1);

    bit_period_timer #(
        .FAST_DIV (FAST_DIV),
        .SLOW_DIV (SLOW_DIV)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_clear),
        .i_sel_fast   (r_freq[r_bit_idx]),
        .o_period_end (w_period_end)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pattern    <= '0;
            r_freq       <= '0;
            r_mode       <= 1'b0;
            r_bit_idx    <= '0;
            r_serial_out <= IDLE_LEVEL;
            r_busy       <= 1'b0;
            r_done_tick  <= 1'b0;
        end else begin
            r_done_tick <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && !i_stop) begin
                        r_state      <= S_SEND;
                        r_pattern    <= i_output_pattern;
                        r_freq       <= i_freq_pattern;
                        r_mode       <= i_mode;
                        r_bit_idx    <= '0;
                        r_serial_out <= i_output_pattern[0];
                        r_busy       <= 1'b1;
                    end else begin
                        r_serial_out <= IDLE_LEVEL;
                        r_busy       <= 1'b0;
                    end
                end
                S_SEND: begin
                    // Priority: stop, then retrigger, then normal bit advance.
                    if (i_stop) begin
                        r_state      <= S_IDLE;
                        r_bit_idx    <= '0;
                        r_serial_out <= IDLE_LEVEL;
                        r_busy       <= 1'b0;
                    end else if (i_start) begin
                        r_pattern    <= i_output_pattern;
                        r_freq       <= i_freq_pattern;
                        r_mode       <= i_mode;
                        r_bit_idx    <= '0;
                        r_serial_out <= i_output_pattern[0];
                    end else if (w_period_end) begin
                        if (w_last_bit) begin
                            r_bit_idx   <= '0;
                            r_done_tick <= 1'b1;
                            if (r_mode == MODE_REPEAT) begin
                                r_serial_out <= r_pattern[0];
                            end else begin
                                r_state      <= S_IDLE;
                                r_serial_out <= IDLE_LEVEL;
                                r_busy       <= 1'b0;
                            end
                        end else begin
                            r_bit_idx    <= w_next_idx;
                            r_serial_out <= r_pattern[w_next_idx];
                        end
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_serial_out <= IDLE_LEVEL;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign o_serial_out = r_serial_out;
    assign o_busy       = r_busy;
    assign o_done_tick  = r_done_tick;

endmodule

// File: tb/tb_diff_freq_serial_tx.sv
// Directed bench for diff_freq_serial_tx with DATA_BIT=8, FAST_DIV=2, SLOW_DIV=4, IDLE_LEVEL=0.
module tb_diff_freq_serial_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] pat;
    logic [7:0] freq;
    logic       mode;
    logic       start;
    logic       stop;
    logic       serial;
    logic       busy;
    logic       done;

    int n_total;
    int n_bad;

    diff_freq_serial_tx #(
        .DATA_BIT   (8),
        .FAST_DIV   (2),
        .SLOW_DIV   (4),
        .IDLE_LEVEL (1'b0)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_output_pattern (pat),
        .i_freq_pattern   (freq),
        .i_mode           (mode),
        .i_start          (start),
        .i_stop           (stop),
        .o_serial_out     (serial),
        .o_busy           (busy),
        .o_done_tick      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] p, input logic [7:0] f, input logic m);
        pat   = p;
        freq  = f;
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_pat;
        n_total = 0;
        n_bad   = 0;
        rst_n = 1'b0;
        pat   = 8'hFF;
        freq  = 8'hFF;
        mode  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;

        // 1: reset held with start pulsing
        for (int i = 0; i < 3; i++) begin
            start = ~start;
            tick();
            chk("rst_serial", serial, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_busy", busy, 1'b0);
            chk("post_rst_serial", serial, 1'b0);
        end

        // 2: one-shot 0xA5 all fast; input change mid-send must be ignored
        exp_pat = 8'hA5;
        do_start(8'hA5, 8'hFF, 1'b0);
        pat = 8'h00;
        for (int c = 0; c < 16; c++) begin
            chk("t2_serial", serial, exp_pat[3'(c / 2)]);
            chk("t2_busy", busy, 1'b1);
            chk("t2_done_low", done, 1'b0);
            tick();
        end
        chk("t2_done", done, 1'b1);
        chk("t2_end_serial", serial, 1'b0);
        chk("t2_end_busy", busy, 1'b0);
        tick();
        chk("t2_done_once", done, 1'b0);

        // 3: one-shot 0xFF, low nibble fast, high nibble slow -> 24 cycles high
        do_start(8'hFF, 8'h0F, 1'b0);
        for (int c = 0; c < 24; c++) begin
            chk("t3_serial", serial, 1'b1);
            chk("t3_done_low", done, 1'b0);
            tick();
        end
        chk("t3_done", done, 1'b1);
        chk("t3_end_serial", serial, 1'b0);
        tick();
        chk("t3_done_once", done, 1'b0);
        chk("t3_idle_busy", busy, 1'b0);

        // 4: repeat 0x01 all slow, stop at cycle 40
        do_start(8'h01, 8'h00, 1'b1);
        for (int c = 0; c < 40; c++) begin
            chk("t4_serial", serial, (c % 32) < 4);
            chk("t4_done", done, c == 32);
            chk("t4_busy", busy, 1'b1);
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t4_stop_serial", serial, 1'b0);
        chk("t4_stop_busy", busy, 1'b0);
        chk("t4_stop_done", done, 1'b0);
        tick();
        chk("t4_stop_done2", done, 1'b0);
        chk("t4_stop_busy2", busy, 1'b0);

        // 5a: start and stop together while idle
        pat   = 8'hFF;
        freq  = 8'hFF;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("t5_both_busy", busy, 1'b0);
        chk("t5_both_serial", serial, 1'b0);
        tick();
        chk("t5_both_busy2", busy, 1'b0);

        // 5b: retrigger at cycle 5 of a 0x00 pass with 0xFF, all slow
        do_start(8'h00, 8'h00, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk("t5_first_serial", serial, 1'b0);
            chk("t5_first_busy", busy, 1'b1);
            tick();
        end
        do_start(8'hFF, 8'h00, 1'b0);
        for (int c = 0; c < 32; c++) begin
            chk("t5_retrig_serial", serial, 1'b1);
            chk("t5_retrig_done", done, 1'b0);
            tick();
        end
        chk("t5_done", done, 1'b1);
        chk("t5_end_serial", serial, 1'b0);

        // 6: reset at cycle 6 of a one-shot, then a clean send
        tick();
        do_start(8'hFF, 8'hFF, 1'b0);
        for (int c = 0; c < 6; c++) begin
            chk("t6_serial", serial, 1'b1);
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_rst_serial", serial, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_done", done, 1'b0);
        tick();
        chk("t6_rst_done2", done, 1'b0);
        chk("t6_rst_busy2", busy, 1'b0);
        exp_pat = 8'h0F;
        do_start(8'h0F, 8'hFF, 1'b0);
        for (int c = 0; c < 16; c++) begin
            chk("t6_new_serial", serial, exp_pat[3'(c / 2)]);
            chk("t6_new_busy", busy, 1'b1);
            tick();
        end
        chk("t6_new_done", done, 1'b1);
        chk("t6_new_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
